king_square_finder: RTL and testbench
=====================================

// Module: king_square_finder
// PURPOSE
// - Multi-cycle board scanner that locates the king of a requested colour on the 64-square board.
// - Also counts how many such kings are present.
// - Successor to the single-square king check: the caller no longer supplies a position; this block searches for it.
// - Sits between the board register and the check/legal-move logic.
// - Scan width is parametrised (LANES squares per cycle), trading area for latency.
// PARAMETERS
// - LANES  default 4  squares examined per scan cycle; legal values 1,2,4,8,16,32,64 (must divide 64)
// PORTS
// - clk           in   1        clock; all state updates on rising edge
// - rst           in   1        synchronous reset, active-high
// - start         in   1        request a scan; sampled only in IDLE
// - playing       in   color_t  colour whose king is searched; latched with start
// - board         in   fullpiece_t [63:0]  board; snapshot latched on the accepted start
// - busy          out  1        high from the cycle after an accepted start until done
// - done          out  1        one-cycle pulse when the results are valid
// - found         out  1        at least one matching king exists
// - kingPosition  out  6        lowest board index holding a matching king; 0 if none
// - kingCount     out  7        number of matching kings, 0..64
// - multiKing     out  1        kingCount > 1 (illegal-position flag)
// BEHAVIOUR
// - A square matches when board[i].piece == KING and board[i].color == latched playing.
// - Reset: state=IDLE; busy=0, done=0, found=0, kingPosition=0, kingCount=0, multiKing=0; snapshot and index cleared.
// - FSM states are IDLE, SCAN and FINISH.
// - IDLE, start=1:
//   - latch board and playing, clear the accumulators, set idx=0 and go to SCAN.
//   - busy=1 from the next cycle.
// - IDLE, start=0: hold all outputs.
//   - found/kingPosition/kingCount/multiKing keep their last results until the next accepted start.
// - SCAN:
//   - Each cycle examines snapshot squares idx..idx+LANES-1.
//   - The in-group match with the lowest index updates kingPosition only if nothing was found in earlier groups (first-match-wins, ascending order).
//   - kingCount += popcount of the matches in the group; the accumulator is 7 bits wide and never wraps (max 64).
//   - idx += LANES. When the group just examined ends at square 63, go to FINISH.
// - FINISH:
//   - done=1 for exactly this cycle, busy=0.
//   - Outputs found / kingPosition / kingCount / multiKing become visible in this cycle and stay stable afterwards.
//   - Then return to IDLE.
// - Latency: start accepted at cycle T -> done at cycle T + 64/LANES + 1 (LANES=4: T+17; LANES=64: T+2).
// - Changes on board/playing after the accepted start do not affect the running scan (snapshot semantics).
// - start while busy (SCAN or FINISH) is ignored; no queuing.
//   - start in the FINISH cycle is also ignored; the caller re-asserts it in IDLE.
// - Results fields are updated only at the transition into FINISH.
//   - During SCAN they show the previous scan's results; the working accumulators are internal.
// - rst during SCAN or FINISH:
//   - next cycle IDLE with reset values, no done pulse.
//   - The aborted scan's results are discarded.
// - No match at all: found=0, kingPosition=0, kingCount=0, multiKing=0.
// - Square 63 is treated as a normal square; there is no index wrap, because idx stops at 64-LANES.
// TESTING
// 1. Standard start position, playing=WHITE, LANES=4:
//    -> done at T+17, found=1, kingPosition=4, kingCount=1, multiKing=0.
// 2. Same board, playing=BLACK -> kingPosition=60, kingCount=1.
// 3. Board with black kings on 7, 8 and 63, playing=BLACK:
//    -> kingPosition=7, kingCount=3, multiKing=1; repeat with LANES=1,8,64 and check identical results and latency 65/9/2.
// 4. Empty board -> found=0, kingPosition=0, kingCount=0.
//    All 64 squares white king -> kingCount=64, kingPosition=0.
// 5. Overwrite board with a king on 33 two cycles after start:
//    -> result reflects the snapshot only; pulse start at busy cycles 3 and 10 and in the FINISH cycle -> exactly one done.
// 6. rst at scan cycle 5 -> no done, all outputs 0 next cycle.
//    A new start then completes normally with correct results.

Source files
------------

// File: rtl/king_square_finder.sv
// Board scanner: finds the lowest-index king of the requested colour and counts all such kings,
// examining LANES squares per cycle from a snapshot latched on start.
package king_square_finder_pkg;
   typedef enum logic {WHITE = 1'b0, BLACK = 1'b1} color_t;
   typedef enum logic [2:0] {
      EMPTY  = 3'd0,
      PAWN   = 3'd1,
      KNIGHT = 3'd2,
      BISHOP = 3'd3,
      ROOK   = 3'd4,
      QUEEN  = 3'd5,
      KING   = 3'd6
   } piece_t;
   typedef struct packed {
      color_t color;
      piece_t piece;
   } fullpiece_t;
endpackage

module king_square_finder
   import king_square_finder_pkg::*;
#(
   parameter int unsigned LANES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  color_t            playing,
   input  fullpiece_t [63:0] board,
   output logic              busy,
   output logic              done,
   output logic              found,
   output logic [5:0]        kingPosition,
   output logic [6:0]        kingCount,
   output logic              multiKing
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SCAN   = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   localparam logic [5:0] LAST_IDX = 6'(64 - LANES);
   localparam logic [5:0] STEP     = 6'(LANES);

   logic [1:0]        state;
   fullpiece_t [63:0] snap;
   color_t            color_q;
   logic [5:0]        idx;

   logic              acc_found;
   logic [5:0]        acc_pos;
   logic [6:0]        acc_cnt;

   logic [LANES-1:0]  match;
   logic              grp_any;
   logic [5:0]        grp_first;
   logic [6:0]        grp_pop;
   logic              nxt_found;
   logic [5:0]        nxt_pos;
   logic [6:0]        nxt_cnt;

   always_comb begin
      match     = '0;
      grp_any   = 1'b0;
      grp_first = '0;
      grp_pop   = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         match[i] = (snap[idx + 6'(i)].piece == KING) && (snap[idx + 6'(i)].color == color_q);
         if (match[i]) begin
            if (!grp_any) grp_first = idx + 6'(i);
            grp_any = 1'b1;
            grp_pop = grp_pop + 7'd1;
         end
      end
   end

   // An earlier group's hit always wins, so the position only moves while nothing is found yet.
   always_comb begin
      nxt_found = acc_found | grp_any;
      nxt_pos   = acc_found ? acc_pos : (grp_any ? grp_first : 6'd0);
      nxt_cnt   = acc_cnt + grp_pop;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         snap         <= '0;
         color_q      <= WHITE;
         idx          <= '0;
         acc_found    <= 1'b0;
         acc_pos      <= '0;
         acc_cnt      <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         found        <= 1'b0;
         kingPosition <= '0;
         kingCount    <= '0;
         multiKing    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  snap      <= board;
                  color_q   <= playing;
                  idx       <= '0;
                  acc_found <= 1'b0;
                  acc_pos   <= '0;
                  acc_cnt   <= '0;
                  busy      <= 1'b1;
                  state     <= SCAN;
               end
            end
            SCAN: begin
               acc_found <= nxt_found;
               acc_pos   <= nxt_pos;
               acc_cnt   <= nxt_cnt;
               if (idx == LAST_IDX) begin
                  state        <= FINISH;
                  busy         <= 1'b0;
                  done         <= 1'b1;
                  found        <= nxt_found;
                  kingPosition <= nxt_pos;
                  kingCount    <= nxt_cnt;
                  multiKing    <= (nxt_cnt > 7'd1);
               end else begin
                  idx <= idx + STEP;
               end
            end
            FINISH: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_king_square_finder.sv
// Scoreboard bench for king_square_finder: a reference scan model queues expected results at each
// accepted start; lane variants 4/1/8/64 share the stimulus.
module tb_king_square_finder;
   import king_square_finder_pkg::*;

   typedef struct {
      bit found;
      int pos;
      int cnt;
      bit multi;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   color_t            playing;
   fullpiece_t [63:0] board;

   logic [3:0]        busy_v, done_v, found_v, multi_v;
   logic [3:0][5:0]   pos_v;
   logic [3:0][6:0]   cnt_v;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   prev_cnt = 0;
   int   lat_tab[4] = '{17, 65, 9, 2};

   always #5 clk = ~clk;

   king_square_finder #(.LANES(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .playing(playing), .board(board),
      .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
      .kingPosition(pos_v[0]), .kingCount(cnt_v[0]), .multiKing(multi_v[0]));
   king_square_finder #(.LANES(1)) u_l1 (
      .clk(clk), .rst(rst), .start(start), .playing(playing), .board(board),
      .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
      .kingPosition(pos_v[1]), .kingCount(cnt_v[1]), .multiKing(multi_v[1]));
   king_square_finder #(.LANES(8)) u_l8 (
      .clk(clk), .rst(rst), .start(start), .playing(playing), .board(board),
      .busy(busy_v[2]), .done(done_v[2]), .found(found_v[2]),
      .kingPosition(pos_v[2]), .kingCount(cnt_v[2]), .multiKing(multi_v[2]));
   king_square_finder #(.LANES(64)) u_l64 (
      .clk(clk), .rst(rst), .start(start), .playing(playing), .board(board),
      .busy(busy_v[3]), .done(done_v[3]), .found(found_v[3]),
      .kingPosition(pos_v[3]), .kingCount(cnt_v[3]), .multiKing(multi_v[3]));

   function automatic exp_t model(input fullpiece_t [63:0] b, input color_t c);
      exp_t e;
      e.found = 0;
      e.pos   = 0;
      e.cnt   = 0;
      for (int i = 0; i < 64; i++) begin
         if (b[i].piece == KING && b[i].color == c) begin
            if (!e.found) e.pos = i;
            e.found = 1;
            e.cnt++;
         end
      end
      e.multi = (e.cnt > 1);
      return e;
   endfunction

   task automatic load_standard();
      piece_t back[8] = '{ROOK, KNIGHT, BISHOP, QUEEN, KING, BISHOP, KNIGHT, ROOK};
      board = '0;
      for (int f = 0; f < 8; f++) begin
         board[f]      = '{color: WHITE, piece: back[f]};
         board[8 + f]  = '{color: WHITE, piece: PAWN};
         board[48 + f] = '{color: BLACK, piece: PAWN};
         board[56 + f] = '{color: BLACK, piece: back[f]};
      end
   endtask

   // Leaves the caller on the falling edge of the first busy cycle (latency count 1).
   task automatic issue_start(input color_t c);
      @(negedge clk);
      playing = c;
      start   = 1'b1;
      exp_q.push_back(model(board, c));
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int k, input int limit, inout int lat, output bit ok);
      while (!done_v[k] && lat < limit) begin
         @(negedge clk);
         lat++;
      end
      ok = done_v[k];
   endtask

   task automatic wait_all_idle();
      int n = 0;
      while ((busy_v != 4'b0 || done_v != 4'b0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (busy_v != 4'b0 || done_v != 4'b0) begin
         errors++;
         $display("FAIL idle_wait busy=%b done=%b want 0000/0000", busy_v, done_v);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if ({busy_v[k], done_v[k], found_v[k], multi_v[k]} !== 4'b0 || pos_v[k] !== 6'd0 || cnt_v[k] !== 7'd0) begin
            errors++;
            $display("FAIL reset_state lane%0d busy=%b done=%b found=%b pos=%0d cnt=%0d multi=%b want all 0",
                     k, busy_v[k], done_v[k], found_v[k], pos_v[k], cnt_v[k], multi_v[k]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_start_position();
      color_t cols[2] = '{WHITE, BLACK};
      load_standard();
      foreach (cols[j]) begin
         int   lat = 1;
         bit   ok;
         exp_t e;
         issue_start(cols[j]);
         checks++;
         if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", busy_v[0]);
         end
         wait_done(0, 40, lat, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || lat !== 17) begin
            errors++;
            $display("FAIL start_pos_latency col=%0d got %0d (seen=%0d) want 17", cols[j], lat, ok);
         end
         checks++;
         if (found_v[0] !== e.found || pos_v[0] !== 6'(e.pos) || cnt_v[0] !== 7'(e.cnt) || multi_v[0] !== e.multi
             || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL start_pos_result col=%0d got f=%b p=%0d c=%0d m=%b busy=%b want f=%b p=%0d c=%0d m=%b busy=0",
                     cols[j], found_v[0], pos_v[0], cnt_v[0], multi_v[0], busy_v[0], e.found, e.pos, e.cnt, e.multi);
         end
         @(negedge clk);
         checks++;
         if (done_v[0] !== 1'b0 || pos_v[0] !== 6'(e.pos) || cnt_v[0] !== 7'(e.cnt)) begin
            errors++;
            $display("FAIL result_hold done=%b p=%0d c=%0d want done=0 p=%0d c=%0d",
                     done_v[0], pos_v[0], cnt_v[0], e.pos, e.cnt);
         end
      end
   endtask

   task automatic test_empty_and_full();
      for (int j = 0; j < 2; j++) begin
         int   lat = 1;
         bit   ok;
         exp_t e;
         board = '0;
         if (j == 1) for (int i = 0; i < 64; i++) board[i] = '{color: WHITE, piece: KING};
         issue_start(WHITE);
         wait_done(0, 40, lat, ok);
         e = exp_q.pop_front();
         checks++;
         if (!ok || found_v[0] !== e.found || pos_v[0] !== 6'(e.pos) || cnt_v[0] !== 7'(e.cnt) || multi_v[0] !== e.multi) begin
            errors++;
            $display("FAIL empty_full%0d got done=%b f=%b p=%0d c=%0d m=%b want done=1 f=%b p=%0d c=%0d m=%b",
                     j, ok, found_v[0], pos_v[0], cnt_v[0], multi_v[0], e.found, e.pos, e.cnt, e.multi);
         end
      end
   endtask

   task automatic test_snapshot_and_ignored_start();
      int   dones = 0;
      int   dlat = 0;
      logic rf, rm;
      logic [5:0] rp;
      logic [6:0] rc;
      exp_t e;
      rf = 0; rm = 0; rp = '0; rc = '0;
      load_standard();
      issue_start(WHITE);
      for (int lat = 1; lat <= 60; lat++) begin
         start = 1'b0;
         if (lat == 2) begin
            board[33] = '{color: WHITE, piece: KING};
            board[4]  = '{color: WHITE, piece: EMPTY};
            playing   = BLACK;
         end
         if (lat == 3 || lat == 10) start = 1'b1;
         if (done_v[0]) begin
            dones++;
            if (dones == 1) begin
               dlat = lat;
               rf = found_v[0]; rp = pos_v[0]; rc = cnt_v[0]; rm = multi_v[0];
               start = 1'b1;
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (dones !== 1 || dlat !== 17) begin
         errors++;
         $display("FAIL ignored_start dones=%0d at lat %0d want 1 at 17", dones, dlat);
      end
      checks++;
      if (rf !== e.found || rp !== 6'(e.pos) || rc !== 7'(e.cnt) || rm !== e.multi) begin
         errors++;
         $display("FAIL snapshot got f=%b p=%0d c=%0d m=%b want f=%b p=%0d c=%0d m=%b",
                  rf, rp, rc, rm, e.found, e.pos, e.cnt, e.multi);
      end
      checks++;
      if (busy_v[0] !== 1'b0) begin
         errors++;
         $display("FAIL finish_start_busy got %b want 0", busy_v[0]);
      end
   endtask

   task automatic test_lanes();
      int   dlat[4];
      bit   seen[4];
      logic rf[4], rm[4];
      logic [5:0] rp[4];
      logic [6:0] rc[4];
      exp_t e;
      wait_all_idle();
      board = '0;
      board[4]  = '{color: WHITE, piece: KING};
      board[7]  = '{color: BLACK, piece: KING};
      board[8]  = '{color: BLACK, piece: KING};
      board[63] = '{color: BLACK, piece: KING};
      board[62] = '{color: BLACK, piece: QUEEN};
      for (int k = 0; k < 4; k++) begin
         seen[k] = 0; dlat[k] = 0; rf[k] = 0; rm[k] = 0; rp[k] = '0; rc[k] = '0;
      end
      issue_start(BLACK);
      for (int lat = 1; lat <= 80; lat++) begin
         for (int k = 0; k < 4; k++) begin
            if (done_v[k] && !seen[k]) begin
               seen[k] = 1; dlat[k] = lat;
               rf[k] = found_v[k]; rp[k] = pos_v[k]; rc[k] = cnt_v[k]; rm[k] = multi_v[k];
            end
         end
         @(negedge clk);
      end
      e = exp_q.pop_front();
      prev_cnt = e.cnt;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (!seen[k] || dlat[k] !== lat_tab[k]) begin
            errors++;
            $display("FAIL lane_latency lane%0d got %0d (seen=%0d) want %0d", k, dlat[k], seen[k], lat_tab[k]);
         end
         checks++;
         if (rf[k] !== e.found || rp[k] !== 6'(e.pos) || rc[k] !== 7'(e.cnt) || rm[k] !== e.multi) begin
            errors++;
            $display("FAIL lane_result lane%0d got f=%b p=%0d c=%0d m=%b want f=%b p=%0d c=%0d m=%b",
                     k, rf[k], rp[k], rc[k], rm[k], e.found, e.pos, e.cnt, e.multi);
         end
      end
   endtask

   task automatic test_abort_reset();
      int   lat = 1;
      int   dones = 0;
      bit   ok;
      exp_t e;
      wait_all_idle();
      load_standard();
      issue_start(WHITE);
      while (lat < 5) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (busy_v[0] !== 1'b1 || cnt_v[0] !== 7'(prev_cnt)) begin
         errors++;
         $display("FAIL scan_holds_prev busy=%b cnt=%0d want busy=1 cnt=%0d", busy_v[0], cnt_v[0], prev_cnt);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      void'(exp_q.pop_front());
      checks++;
      if ({busy_v[0], done_v[0], found_v[0], multi_v[0]} !== 4'b0 || pos_v[0] !== 6'd0 || cnt_v[0] !== 7'd0) begin
         errors++;
         $display("FAIL abort_state busy=%b done=%b f=%b p=%0d c=%0d m=%b want all 0",
                  busy_v[0], done_v[0], found_v[0], pos_v[0], cnt_v[0], multi_v[0]);
      end
      repeat (30) begin
         if (done_v[0]) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones !== 0) begin
         errors++;
         $display("FAIL abort_no_done got %0d done pulses want 0", dones);
      end
      lat = 1;
      issue_start(BLACK);
      wait_done(0, 40, lat, ok);
      e = exp_q.pop_front();
      checks++;
      if (!ok || lat !== 17 || found_v[0] !== e.found || pos_v[0] !== 6'(e.pos) || cnt_v[0] !== 7'(e.cnt)
          || multi_v[0] !== e.multi) begin
         errors++;
         $display("FAIL after_abort lat=%0d f=%b p=%0d c=%0d m=%b want lat=17 f=%b p=%0d c=%0d m=%b",
                  lat, found_v[0], pos_v[0], cnt_v[0], multi_v[0], e.found, e.pos, e.cnt, e.multi);
      end
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      playing = WHITE;
      board   = '0;
      test_reset();
      test_start_position();
      test_empty_and_full();
      test_snapshot_and_ignored_start();
      test_lanes();
      test_abort_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
